// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the SR bank driver.
// Commands are packed {S,R}; SR_ILLEGAL must never reach the bank.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_REPORT
  } state_e;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_CLR     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [1:0] sr_cmd(
    input logic t,
    input logic q
  );
    logic [1:0] c;
    c = SR_HOLD;
    unique case (1'b1)
      (t == q):   c = SR_HOLD;
      (t && !q):  c = SR_SET;
      (!t && q):  c = SR_CLR;
      default:    c = SR_HOLD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// Request and result handshakes of the SR bank driver.
// master = control logic, slave = driver.
interface sr_bank_driver_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 1
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_target;
  logic             done_valid;
  logic             done_ready;
  logic             done_ok;
  logic [WIDTH-1:0] done_mismatch;
  logic [RW-1:0]    done_retries;

  modport master (
    output req_valid,
    output req_target,
    output done_ready,
    input  req_ready,
    input  done_valid,
    input  done_ok,
    input  done_mismatch,
    input  done_retries
  );

  modport slave (
    input  req_valid,
    input  req_target,
    input  done_ready,
    output req_ready,
    output done_valid,
    output done_ok,
    output done_mismatch,
    output done_retries
  );

endinterface

// File: rtl/sr_cmd_encode.sv
// Maps (target, q_snap) to per-bit S/R commands.
// Only changing bits get a command; S and R are never both set.
module sr_cmd_encode
  import sr_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_snap,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] cmd;
    assign cmd  = sr_cmd(target[i], q_snap[i]);
    // masking keeps the bank safe even from an illegal code
    assign s[i] = cmd[1] & ~cmd[0];
    assign r[i] = cmd[0] & ~cmd[1];
  end

endmodule

// File: rtl/sr_bank_driver.sv
// Drives an SR flip-flop bank to a target pattern, then
// verifies readback with a bounded number of re-drives.
module sr_bank_driver
  import sr_drv_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic             clk,
  input  logic             reset,
  sr_bank_driver_if.slave  bus,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_in
);

  localparam int RW = clog2_min1(MAX_RETRY + 1);
  localparam int CW = clog2_min1(SETTLE + 1);
  localparam logic [RW-1:0] MAXR  = RW'(MAX_RETRY);
  localparam logic [CW-1:0] SLOAD = CW'(SETTLE - 1);

  state_e           state;
  state_e           state_n;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] tgt_sel;
  logic [WIDTH-1:0] s_enc;
  logic [WIDTH-1:0] r_enc;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    retries;
  logic             rdy;
  logic             match;
  logic             accept;
  logic             retry;
  logic             finish;
  logic             drive_go;

  logic             dv;
  logic             dok;
  logic [WIDTH-1:0] dmm;
  logic [RW-1:0]    drt;

  assign match   = (q_in == tgt);
  // the target is not registered yet on the accept edge
  assign tgt_sel = (state == ST_IDLE) ? bus.req_target : tgt;

  sr_cmd_encode #(
    .WIDTH (WIDTH)
  ) u_enc (
    .target (tgt_sel),
    .q_snap (q_in),
    .s      (s_enc),
    .r      (r_enc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    retry   = 1'b0;
    finish  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid && rdy) begin
          state_n = ST_DRIVE;
          accept  = 1'b1;
        end
      end
      ST_DRIVE: begin
        state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (match) begin
          state_n = ST_REPORT;
          finish  = 1'b1;
        end else if (retries < MAXR) begin
          state_n = ST_DRIVE;
          retry   = 1'b1;
        end else begin
          state_n = ST_REPORT;
          finish  = 1'b1;
        end
      end
      ST_REPORT: begin
        if (bus.done_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign drive_go = accept | retry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s       <= '0;
      r       <= '0;
      rdy     <= 1'b0;
      tgt     <= '0;
      cnt     <= '0;
      retries <= '0;
    end else begin
      s   <= drive_go ? s_enc : '0;
      r   <= drive_go ? r_enc : '0;
      rdy <= (state_n == ST_IDLE);
      if (accept) begin
        tgt <= bus.req_target;
      end
      if (state == ST_DRIVE) begin
        cnt <= SLOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (accept) begin
        retries <= '0;
      end else if (retry) begin
        retries <= retries + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv  <= 1'b0;
      dok <= 1'b0;
      dmm <= '0;
      drt <= '0;
    end else begin
      dv <= (state_n == ST_REPORT);
      if (finish) begin
        dok <= match;
        dmm <= q_in ^ tgt;
        drt <= retries;
      end
    end
  end

  assign bus.req_ready     = rdy;
  assign bus.done_valid    = dv;
  assign bus.done_ok       = dok;
  assign bus.done_mismatch = dmm;
  assign bus.done_retries  = drt;

  sr_exclusive_a: assert property (
    @(posedge clk) disable iff (!reset) ((s & r) == '0)
  );

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: SR bank model with stuck-at-0
// injection, directed table, random requests, reset cases.
module tb_sr_bank_driver;
  import sr_drv_pkg::*;

  localparam int WIDTH     = 8;
  localparam int SETTLE    = 2;
  localparam int MAX_RETRY = 1;
  localparam int RW        = clog2_min1(MAX_RETRY + 1);
  localparam int STEP      = SETTLE + 2;

  typedef struct {
    logic [7:0] t;
    logic [7:0] stk;
    int         stall;
    logic [7:0] es1;
    logic [7:0] er1;
    logic [7:0] es2;
    logic       eok;
    logic [7:0] emm;
    int         ert;
    int         elat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s;
  logic [7:0] r;
  logic [7:0] q_in;
  logic [7:0] qb  = 8'h00;
  logic [7:0] stk = 8'h00;
  logic [7:0] pm  = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         acc[$];
  vec_t       vt[5];

  sr_bank_driver_if #(.WIDTH(WIDTH), .RW(RW)) bus ();

  sr_bank_driver #(
    .WIDTH     (WIDTH),
    .SETTLE    (SETTLE),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .s     (s),
    .r     (r),
    .q_in  (q_in)
  );

  always #5 clk = ~clk;

  // behavioural SR bank; stuck bits read back as 0
  assign q_in = qb & ~stk;

  always @(posedge clk) begin
    qb  <= (qb | s) & ~r;
    cyc <= cyc + 1;
    if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1)
      acc.push_back(cyc);
  end

  always @(negedge clk) begin
    n_cmp++;
    if ((s & r) !== 8'h00) begin
      n_bad++;
      $display("FAIL sr_exclusive: s&r=%h want 00", s & r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  function automatic vec_t model(input logic [7:0] t,
                                 input logic [7:0] k,
                                 input int st,
                                 input logic [7:0] phys);
    vec_t v;
    logic [7:0] rd;
    rd     = phys & ~k;
    v.t    = t;
    v.stk  = k;
    v.stall = st;
    v.es1  = t & ~rd;
    v.er1  = ~t & rd;
    v.eok  = ((t & k) == 8'h00);
    v.ert  = v.eok ? 0 : MAX_RETRY;
    v.emm  = t & k;
    v.es2  = t & k;
    v.elat = SETTLE + 3 + v.ert * STEP;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    int w;
    bit quiet;
    logic [7:0] sv[64];
    logic [7:0] rv[64];
    stk = v.stk;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk($sformatf("%s_ready", tag), bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_target = v.t;
    tick();
    bus.req_valid  = 1'b0;
    bus.req_target = ~v.t;
    lat = 1;
    sv[1] = s;
    rv[1] = r;
    while (bus.done_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      sv[lat] = s;
      rv[lat] = r;
    end
    chk($sformatf("%s_latency", tag), lat, v.elat);
    chk($sformatf("%s_s1", tag), sv[1], v.es1);
    chk($sformatf("%s_r1", tag), rv[1], v.er1);
    if (v.ert > 0) begin
      chk($sformatf("%s_s2", tag), sv[1+STEP], v.es2);
      chk($sformatf("%s_r2", tag), rv[1+STEP], 0);
    end
    quiet = 1'b1;
    for (int c = 2; c <= lat; c++) begin
      if (!((c - 1) % STEP == 0 && (c - 1) / STEP <= v.ert) &&
          (sv[c] | rv[c]) != 8'h00)
        quiet = 1'b0;
    end
    chk($sformatf("%s_quiet", tag), quiet, 1);
    chk($sformatf("%s_ok", tag), bus.done_ok, v.eok);
    chk($sformatf("%s_mism", tag), bus.done_mismatch, v.emm);
    chk($sformatf("%s_retries", tag), bus.done_retries, v.ert);
    for (int k = 0; k < v.stall; k++) begin
      bus.req_valid  = 1'b1;
      bus.req_target = ~v.t;
      tick();
      chk($sformatf("%s_hold_dv", tag), bus.done_valid, 1);
      chk($sformatf("%s_hold_ok", tag), bus.done_ok, v.eok);
      chk($sformatf("%s_hold_mm", tag), bus.done_mismatch, v.emm);
      chk($sformatf("%s_hold_rt", tag), bus.done_retries, v.ert);
      chk($sformatf("%s_hold_rdy", tag), bus.req_ready, 0);
    end
    bus.req_valid  = 1'b0;
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    chk($sformatf("%s_dv_drop", tag), bus.done_valid, 0);
    chk($sformatf("%s_rdy_back", tag), bus.req_ready, 1);
    chk($sformatf("%s_q", tag), q_in, v.t & ~v.stk);
  endtask

  task automatic rst_mid(input string tag, input int at);
    logic [7:0] t;
    stk = 8'h00;
    t = ~pm;
    bus.req_valid  = 1'b1;
    bus.req_target = t;
    tick();
    bus.req_valid  = 1'b0;
    repeat (at - 1) tick();
    chk($sformatf("%s_pre_s", tag), s, (at == 1) ? (t & ~pm) : 8'h00);
    reset = 1'b0;
    #1;
    chk($sformatf("%s_s0", tag), s, 0);
    chk($sformatf("%s_r0", tag), r, 0);
    chk($sformatf("%s_dv0", tag), bus.done_valid, 0);
    chk($sformatf("%s_rdy0", tag), bus.req_ready, 0);
    repeat (3) tick();
    chk($sformatf("%s_dv_hold", tag), bus.done_valid, 0);
    reset = 1'b1;
    chk($sformatf("%s_rdy_rel", tag), bus.req_ready, 0);
    tick();
    chk($sformatf("%s_rdy_up", tag), bus.req_ready, 1);
    if (at != 1) pm = t;
    chk($sformatf("%s_bank", tag), q_in, pm);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    int w;
    int gap;
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] one;
    vec_t v;

    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_target = 8'h00;
    bus.done_ready = 1'b0;
    repeat (2) tick();
    chk("rst_s", s, 0);
    chk("rst_r", r, 0);
    chk("rst_dv", bus.done_valid, 0);
    chk("rst_ok", bus.done_ok, 0);
    chk("rst_mm", bus.done_mismatch, 0);
    chk("rst_rt", bus.done_retries, 0);
    chk("rst_rdy", bus.req_ready, 0);
    reset = 1'b1;
    chk("rel_rdy_before", bus.req_ready, 0);
    tick();
    chk("rel_rdy_after", bus.req_ready, 1);

    vt[0] = '{8'hA5, 8'h00, 0, 8'hA5, 8'h00, 8'h00, 1'b1, 8'h00, 0, 5};
    vt[1] = '{8'h3C, 8'h00, 0, 8'h18, 8'h81, 8'h00, 1'b1, 8'h00, 0, 5};
    vt[2] = '{8'h3C, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 0, 5};
    vt[3] = '{8'hFF, 8'h04, 0, 8'hC7, 8'h00, 8'h04, 1'b0, 8'h04, 1, 9};
    vt[4] = '{8'h0F, 8'h00, 4, 8'h00, 8'hF0, 8'h00, 1'b1, 8'h00, 0, 5};
    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i]);
      pm = vt[i].t | (pm & vt[i].stk);
    end

    one = 8'h01;
    for (int n = 0; n < 24; n++) begin
      x1 = 8'($urandom);
      x2 = ($urandom_range(0, 3) == 0) ?
           (one << $urandom_range(0, 7)) : 8'h00;
      v = model(x1, x2, $urandom_range(0, 3), pm);
      run_vec($sformatf("rnd%0d", n), v);
      pm = v.t | (pm & v.stk);
    end

    stk = 8'h00;
    acc.delete();
    x1 = 8'($urandom);
    x2 = 8'($urandom);
    bus.done_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_target = x1;
    w = 0;
    while (acc.size() < 1 && w < 30) begin
      tick();
      w++;
    end
    bus.req_target = x2;
    while (acc.size() < 2 && w < 60) begin
      tick();
      w++;
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 2);
    gap = (acc.size() >= 2) ? acc[1] - acc[0] : -1;
    chk("b2b_period", gap, SETTLE + 4);
    repeat (SETTLE + 4) tick();
    bus.done_ready = 1'b0;
    chk("b2b_q", q_in, x2);
    chk("b2b_rdy", bus.req_ready, 1);
    pm = x2;

    rst_mid("rst_drive", 1);
    rst_mid("rst_settle", 2);
    v = model(8'($urandom), 8'h00, 1, pm);
    run_vec("post_rst", v);
    pm = v.t;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
